moving_window_ctrl: RTL and testbench

//  Sequences the moving_stats datapath over a sliding window of the last 2**WINDOW_LOG2 samples.

---
 rtl/moving_window_ctrl.sv | 155 +++++++++++++++
 tb/tb_moving_window_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/moving_window_ctrl.sv
// -----------------------------------------------------------------------------
// moving_window_ctrl
//   Sequencer for the moving_stats datapath over a sliding window of the last
//   N = 2**WINDOW_LOG2 samples. Owns the sample ring buffer, pairs each new
//   sample with the one leaving the window, and issues one incoming/outgoing
//   update per sample. Handles warm-up (outgoing forced to 0 until the window
//   is full), flush/restart and stats-valid qualification.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_valid/o_ready       upstream sample handshake, i_data sample
//   i_flush               synchronous restart: empty window, clear stats
//   o_stats_clear         one-cycle pulse telling moving_stats to zero itself
//   o_update_valid/i_update_ready  update handshake toward moving_stats
//   o_incoming_data       sample entering the window
//   o_outgoing_data       sample leaving the window (0 during warm-up)
//   o_count               samples in window, saturates at N
//   o_window_full         o_count == N
//   o_stats_valid         pulse, moving_stats outputs valid this cycle
//
// Build option
//   MOVING_WINDOW_WARMUP_GATE_EN  when defined, o_stats_valid only pulses for
//                                 handshakes made while the window is full.
//
// States
//   S_CLEAR  | one cycle, o_stats_clear=1, no accept
//   S_ACCEPT | o_ready=1, waiting for an upstream sample
//   S_FETCH  | ring read in flight, load update pair
//   S_ISSUE  | o_update_valid=1, hold until i_update_ready
// -----------------------------------------------------------------------------
module moving_window_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int WINDOW_LOG2 = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_flush,
  output logic                   o_stats_clear,
  output logic                   o_update_valid,
  input  logic                   i_update_ready,
  output logic [DATA_WIDTH-1:0]  o_incoming_data,
  output logic [DATA_WIDTH-1:0]  o_outgoing_data,
  output logic [WINDOW_LOG2:0]   o_count,
  output logic                   o_window_full,
  output logic                   o_stats_valid
);

  localparam logic [1:0] S_CLEAR  = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_FETCH  = 2'd2;
  localparam logic [1:0] S_ISSUE  = 2'd3;

  localparam int                     N        = 1 << WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0]   CNT_FULL = (WINDOW_LOG2+1)'(N);
  localparam logic [WINDOW_LOG2:0]   CNT_ONE  = (WINDOW_LOG2+1)'(1);
  localparam logic [WINDOW_LOG2-1:0] PTR_ONE  = WINDOW_LOG2'(1);

  logic [DATA_WIDTH-1:0]  r_ring [N];
  logic [1:0]             r_state;
  logic [WINDOW_LOG2-1:0] r_wr_ptr;
  logic [WINDOW_LOG2:0]   r_count;
  logic [DATA_WIDTH-1:0]  r_sample;
  logic [DATA_WIDTH-1:0]  r_evict;
  logic                   r_prev_full;
  logic                   r_update_valid;
  logic [DATA_WIDTH-1:0]  r_incoming;
  logic [DATA_WIDTH-1:0]  r_outgoing;
  logic                   r_stats_valid;

  logic w_accept;
  logic w_handshake;
  logic w_full;
  logic w_stats_en;

  assign w_full        = (r_count == CNT_FULL);
  // Reset gating keeps the combinational outputs quiet while reset is held.
  assign o_ready       = (r_state == S_ACCEPT) && !i_flush && !i_reset;
  assign o_stats_clear = (r_state == S_CLEAR) && !i_reset;
  assign w_accept      = o_ready && i_valid;
  // A flush in the same cycle abandons the pending update.
  assign w_handshake   = r_update_valid && i_update_ready && !i_flush;

`ifdef MOVING_WINDOW_WARMUP_GATE_EN
  assign w_stats_en = w_full;
`else
  assign w_stats_en = 1'b1;
`endif

  // Ring storage: read-before-write on the same slot captures the evicted
  // sample; contents are never reset, warm-up gating masks stale slots.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_evict            <= r_ring[r_wr_ptr];
      r_ring[r_wr_ptr]   <= i_data;
      r_sample           <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_state        <= S_CLEAR;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_prev_full    <= 1'b0;
      r_update_valid <= 1'b0;
      r_incoming     <= '0;
      r_outgoing     <= '0;
      r_stats_valid  <= 1'b0;
    end else begin
      r_stats_valid <= w_handshake && w_stats_en;
      case (r_state)
        S_CLEAR: begin
          r_state <= S_ACCEPT;
        end
        S_ACCEPT: begin
          if (w_accept) begin
            r_wr_ptr    <= r_wr_ptr + PTR_ONE;
            r_prev_full <= w_full;
            if (!w_full) begin
              r_count <= r_count + CNT_ONE;
            end
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_incoming     <= r_sample;
          // Nth sample still sees outgoing=0: gate on count before its accept.
          r_outgoing     <= r_prev_full ? r_evict : '0;
          r_update_valid <= 1'b1;
          r_state        <= S_ISSUE;
        end
        S_ISSUE: begin
          if (i_update_ready) begin
            r_update_valid <= 1'b0;
            r_state        <= S_ACCEPT;
          end
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  assign o_update_valid  = r_update_valid;
  assign o_incoming_data = r_incoming;
  assign o_outgoing_data = r_outgoing;
  assign o_count         = r_count;
  assign o_window_full   = w_full;
  assign o_stats_valid   = r_stats_valid;

endmodule

// File: tb/tb_moving_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_moving_window_ctrl
//   Directed bench for moving_window_ctrl at default parameters (N=16).
//   Expected values are hand-derived from the window definition.
// -----------------------------------------------------------------------------
module tb_moving_window_ctrl;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        i_flush;
  logic        o_stats_clear;
  logic        o_update_valid;
  logic        i_update_ready;
  logic [31:0] o_incoming_data;
  logic [31:0] o_outgoing_data;
  logic [4:0]  o_count;
  logic        o_window_full;
  logic        o_stats_valid;

  int checks = 0;
  int errors = 0;
  int n_sv   = 0;

  moving_window_ctrl #(.DATA_WIDTH(32), .WINDOW_LOG2(4)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_data          (i_data),
    .i_flush         (i_flush),
    .o_stats_clear   (o_stats_clear),
    .o_update_valid  (o_update_valid),
    .i_update_ready  (i_update_ready),
    .o_incoming_data (o_incoming_data),
    .o_outgoing_data (o_outgoing_data),
    .o_count         (o_count),
    .o_window_full   (o_window_full),
    .o_stats_valid   (o_stats_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge where o_ready is high (or timeout).
  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (o_ready) break;
      @(negedge clk);
    end
    chk("ready_wait", {31'b0, o_ready}, 32'd1);
  endtask

  function automatic logic [31:0] exp_stats(input int cnt);
`ifdef MOVING_WINDOW_WARMUP_GATE_EN
    return (cnt == 16) ? 32'd1 : 32'd0;
`else
    return 32'd1;
`endif
  endfunction

  // Full sample transaction with i_update_ready held high.
  task automatic send(input logic [31:0] d, input logic [31:0] exp_out, input int exp_cnt);
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    wait_ready();
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    chk("fetch_no_valid", {31'b0, o_update_valid}, 32'd0);
    @(negedge clk);
    chk("issue_valid", {31'b0, o_update_valid}, 32'd1);
    chk("issue_incoming", o_incoming_data, d);
    chk("issue_outgoing", o_outgoing_data, exp_out);
    chk("issue_count", {27'b0, o_count}, exp_cnt);
    chk("issue_full", {31'b0, o_window_full}, (exp_cnt == 16) ? 32'd1 : 32'd0);
    chk("issue_not_ready", {31'b0, o_ready}, 32'd0);
    @(negedge clk);
    chk("stats_valid", {31'b0, o_stats_valid}, exp_stats(exp_cnt));
    if (o_stats_valid) n_sv++;
    chk("post_valid", {31'b0, o_update_valid}, 32'd0);
  endtask

  initial begin
    i_reset        = 1'b1;
    i_valid        = 1'b0;
    i_data         = '0;
    i_flush        = 1'b0;
    i_update_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_update_valid", {31'b0, o_update_valid}, 32'd0);
    chk("rst_stats_clear", {31'b0, o_stats_clear}, 32'd0);
    chk("rst_count", {27'b0, o_count}, 32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd0);
    chk("rst_stats_valid", {31'b0, o_stats_valid}, 32'd0);
    chk("rst_incoming", o_incoming_data, 32'd0);
    chk("rst_outgoing", o_outgoing_data, 32'd0);
    chk("rst_full", {31'b0, o_window_full}, 32'd0);
    i_reset = 1'b0;
    #1;
    chk("clear_pulse", {31'b0, o_stats_clear}, 32'd1);
    chk("clear_not_ready", {31'b0, o_ready}, 32'd0);
    @(negedge clk);
    chk("clear_done", {31'b0, o_stats_clear}, 32'd0);
    chk("accept_ready", {31'b0, o_ready}, 32'd1);

    send(32'h10, 32'h0, 1);

    // Flush from idle, then fill window and wrap twice
    @(negedge clk);
    i_flush = 1'b1;
    #1 chk("flush_not_ready", {31'b0, o_ready}, 32'd0);
    @(posedge clk);
    #1 i_flush = 1'b0;
    @(negedge clk);
    chk("flush_clear_pulse", {31'b0, o_stats_clear}, 32'd1);
    chk("flush_count", {27'b0, o_count}, 32'd0);

    n_sv = 0;
    for (int k = 1; k <= 40; k++) begin
      send(32'(k), (k > 16) ? 32'(k - 16) : 32'd0, (k > 16) ? 16 : k);
      if (k == 16) begin
`ifdef MOVING_WINDOW_WARMUP_GATE_EN
        chk("warmup_pulses", 32'(n_sv), 32'd1);
`else
        chk("warmup_pulses", 32'(n_sv), 32'd16);
`endif
      end
    end

    // Backpressure in ISSUE for 5 cycles, with a competing upstream sample
    i_update_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 32'd41;
    wait_ready();
    @(posedge clk);
    #1 i_data = 32'hDEAD;
    @(negedge clk);
    @(negedge clk);
    chk("stall_valid0", {31'b0, o_update_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, o_update_valid}, 32'd1);
      chk("stall_incoming", o_incoming_data, 32'd41);
      chk("stall_outgoing", o_outgoing_data, 32'd25);
      chk("stall_not_ready", {31'b0, o_ready}, 32'd0);
    end
    i_valid        = 1'b0;
    i_update_ready = 1'b1;
    @(negedge clk);
    chk("stall_released", {31'b0, o_update_valid}, 32'd0);
    chk("stall_stats_valid", {31'b0, o_stats_valid}, 32'd1);
    send(32'd42, 32'd26, 16);

    // Flush while ISSUE holds an update with the window full
    i_update_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 32'd43;
    wait_ready();
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("preflush_valid", {31'b0, o_update_valid}, 32'd1);
    chk("preflush_full", {31'b0, o_window_full}, 32'd1);
    i_flush        = 1'b1;
    i_update_ready = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_valid", {31'b0, o_update_valid}, 32'd0);
    chk("flush_no_stats", {31'b0, o_stats_valid}, 32'd0);
    chk("flush_issue_clear", {31'b0, o_stats_clear}, 32'd1);
    chk("flush_issue_count", {27'b0, o_count}, 32'd0);
    send(32'h55, 32'h0, 1);

    // Valid and flush in the same cycle: sample discarded
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 32'hAA;
    i_flush = 1'b1;
    #1 chk("vflush_not_ready", {31'b0, o_ready}, 32'd0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    send(32'h66, 32'h0, 1);

    // Reset in the middle of a transaction
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 32'h70;
    wait_ready();
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge clk);
    chk("midrst_clear_low", {31'b0, o_stats_clear}, 32'd0);
    @(negedge clk);
    chk("midrst_valid", {31'b0, o_update_valid}, 32'd0);
    chk("midrst_count", {27'b0, o_count}, 32'd0);
    chk("midrst_stats", {31'b0, o_stats_valid}, 32'd0);
    chk("midrst_outgoing", o_outgoing_data, 32'd0);
    i_reset = 1'b0;
    #1 chk("midrst_clear_pulse", {31'b0, o_stats_clear}, 32'd1);
    send(32'h77, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
